// File: rtl/store_data_formatter.sv
// Store-path formatter: turns SB/SH/SW requests into word-aligned, lane-replicated
// data-memory writes queued in a 2-entry FIFO; illegal requests are dropped and flagged.
module store_data_formatter #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_size,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_mem_valid,
  input  logic               i_mem_ready,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic [3:0]         o_mem_be,
  output logic               o_misaligned,
  output logic [NB_ADDR-1:0] o_bad_addr
);

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] data;
    logic [3:0]         be;
  } entry_t;

  entry_t             entry_q [2];
  entry_t             entry_d [2];
  entry_t             new_entry;
  entry_t             head;
  logic [1:0]         count_q, count_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               misaligned_q, misaligned_d;
  logic [NB_ADDR-1:0] bad_addr_q, bad_addr_d;
  logic               legal;
  logic               accept;
  logic               push;
  logic               pop;

  // o_ready looks only at registered count, so memory backpressure never reaches it combinationally.
  assign o_ready     = !i_reset && (count_q != 2'd2);
  assign accept      = i_valid && o_ready;
  assign push        = accept && legal;
  assign o_mem_valid = (count_q != 2'd0);
  assign pop         = o_mem_valid && i_mem_ready;

  assign head         = entry_q[rd_ptr_q];
  assign o_mem_addr   = o_mem_valid ? head.addr : '0;
  assign o_mem_data   = o_mem_valid ? head.data : '0;
  assign o_mem_be     = o_mem_valid ? head.be   : '0;
  assign o_misaligned = misaligned_q;
  assign o_bad_addr   = bad_addr_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    legal          = 1'b0;
    new_entry      = '0;
    new_entry.addr = {i_addr[NB_ADDR-1:2], 2'b00};
    case (size_e'(i_size))
      SIZE_BYTE: begin
        legal          = 1'b1;
        new_entry.data = {4{i_data[7:0]}};
        new_entry.be   = 4'b0001 << i_addr[1:0];
      end
      SIZE_HALF: begin
        legal          = !i_addr[0];
        new_entry.data = {2{i_data[15:0]}};
        new_entry.be   = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        legal          = (i_addr[1:0] == 2'b00);
        new_entry.data = i_data;
        new_entry.be   = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      entry_d[wr_ptr_q] = new_entry;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    misaligned_d = accept && !legal;
    bad_addr_d   = misaligned_d ? i_addr : bad_addr_q;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      misaligned_q <= 1'b0;
      bad_addr_q   <= '0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      misaligned_q <= misaligned_d;
      bad_addr_q   <= bad_addr_d;
    end
  end

  // NOTE: entry storage is not reset; count=0 already masks it from the outputs, so stale data is never visible.
  always_ff @(posedge i_clk) begin
    entry_q <= entry_d;
  end

endmodule
